itcm_ctrl: RTL and testbench

- Responder end of the IFU-to-ITCM instruction fetch interface.
- Accepts fetch commands (valid/ready, byte address) and issues a read to a single-port synchronous ITCM SRAM with 1-cycle read latency.
- Returns instruction words in order on the response channel (valid/ready).
- A 2-entry response buffer absorbs response-side backpressure without losing SRAM data.
- Sits between the IFU and the ITCM RAM macro.

---
 rtl/itcm_ctrl_pkg.sv | 40 ++++
 rtl/itcm_rsp_buf.sv | 63 ++++++
 rtl/itcm_ctrl.sv | 123 ++++++++++++
 tb/tb_itcm_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/itcm_ctrl_pkg.sv
// ============================================================================
//  Module  : itcm_ctrl_pkg
//  Purpose : Shared sizing defaults, constants and helpers for the ITCM
//            fetch responder (itcm_ctrl) and its response buffer.
//            Also provides the default values of ITCM_ADDR_WIDTH, ITCM_RAM_DW
//            and ITCM_RAM_AW, unless they are already defined.
//  Options : ITCM_RSP_ERR_EN (see itcm_ctrl)
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ITCM_ADDR_WIDTH
`define ITCM_ADDR_WIDTH 16
`endif
`ifndef ITCM_RAM_DW
`define ITCM_RAM_DW 32
`endif
`ifndef ITCM_RAM_AW
`define ITCM_RAM_AW (`ITCM_ADDR_WIDTH - 2)
`endif

package itcm_ctrl_pkg;

    // Response buffer depth and the width of its occupancy counter (0..2).
    localparam int unsigned c_BUF_DEPTH = 2;
    localparam int unsigned c_CNT_W     = 2;

    typedef logic [c_CNT_W-1:0] buf_cnt_t;

    // A new command may only be accepted if every read already issued or
    // buffered still has a guaranteed buffer slot: count + pend < depth.
    function automatic logic cmd_slot_free(input buf_cnt_t count, input logic pend);
        logic [c_CNT_W:0] w_used;
        w_used = {1'b0, count} + {{c_CNT_W{1'b0}}, pend};
        return (w_used < (c_CNT_W+1)'(c_BUF_DEPTH));
    endfunction

endpackage : itcm_ctrl_pkg

`default_nettype wire

// File: rtl/itcm_rsp_buf.sv
// ============================================================================
//  Module  : itcm_rsp_buf
//  Purpose : 2-entry in-order FIFO holding SRAM read data that could not be
//            delivered to the IFU in the cycle it arrived.
//  Ports   : clk, rst_n      - clock, asynchronous active-low reset
//            i_push, i_din   - enqueue i_din at the tail
//            i_pop           - remove the head
//            o_head          - current head entry (valid when o_count != 0)
//            o_count         - occupancy 0..2
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module itcm_rsp_buf
    import itcm_ctrl_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_head,
    output buf_cnt_t     o_count
);

    logic [W-1:0] r_mem [c_BUF_DEPTH];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    buf_cnt_t     r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(c_BUF_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule : itcm_rsp_buf

`default_nettype wire

// File: rtl/itcm_ctrl.sv
// ============================================================================
//  Module  : itcm_ctrl
//  Purpose : Responder end of the IFU-to-ITCM fetch interface. Converts
//            valid/ready fetch commands into single-cycle SRAM reads and
//            returns the words in order, with a 2-entry buffer absorbing
//            response backpressure.
//  Ports   : clk, rst_n                        - clock, async active-low reset
//            ifu2itcm_cmd_valid/ready/addr     - fetch command channel
//            ifu2itcm_rsp_valid/ready/rdata    - fetch response channel
//            ifu2itcm_rsp_err                  - misaligned flag (option only)
//            itcm_ram_cs/addr/dout             - SRAM macro interface
//  Options : ITCM_RSP_ERR_EN - when defined, a fetch with addr[1:0] != 0 is
//            flagged on ifu2itcm_rsp_err alongside its response.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ITCM_ADDR_WIDTH
`define ITCM_ADDR_WIDTH 16
`endif
`ifndef ITCM_RAM_DW
`define ITCM_RAM_DW 32
`endif

module itcm_ctrl
    import itcm_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = `ITCM_ADDR_WIDTH,
    parameter int unsigned DW     = `ITCM_RAM_DW,
    parameter int unsigned RAM_AW = ADDR_W - 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifu2itcm_cmd_valid,
    output logic              ifu2itcm_cmd_ready,
    input  logic [ADDR_W-1:0] ifu2itcm_cmd_addr,
    output logic              ifu2itcm_rsp_valid,
    input  logic              ifu2itcm_rsp_ready,
    output logic [DW-1:0]     ifu2itcm_rsp_rdata,
`ifdef ITCM_RSP_ERR_EN
    output logic              ifu2itcm_rsp_err,
`endif
    output logic              itcm_ram_cs,
    output logic [RAM_AW-1:0] itcm_ram_addr,
    input  logic [DW-1:0]     itcm_ram_dout
);

`ifdef ITCM_RSP_ERR_EN
    localparam int unsigned c_BUF_W = DW + 1;
`else
    localparam int unsigned c_BUF_W = DW;
`endif

    logic               r_pend;
    logic               w_cmd_hs;
    logic               w_buf_empty;
    logic               w_push;
    logic               w_pop;
    logic [c_BUF_W-1:0] w_push_data;
    logic [c_BUF_W-1:0] w_head;
    buf_cnt_t           w_count;

    // cmd_ready depends on registered state only, so no comb path from valid.
    assign ifu2itcm_cmd_ready = cmd_slot_free(w_count, r_pend);
    assign w_cmd_hs           = ifu2itcm_cmd_valid & ifu2itcm_cmd_ready;

    assign itcm_ram_cs   = w_cmd_hs;
    assign itcm_ram_addr = ifu2itcm_cmd_addr[ADDR_W-1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= w_cmd_hs;
        end
    end

    assign w_buf_empty = (w_count == '0);

    // SRAM data bypasses the buffer only when nothing is queued ahead of it
    // and the IFU takes it immediately; otherwise it must be captured now,
    // because the SRAM output is only valid for this one cycle.
    assign w_push = r_pend & ~(w_buf_empty & ifu2itcm_rsp_ready);
    assign w_pop  = ~w_buf_empty & ifu2itcm_rsp_ready;

    assign ifu2itcm_rsp_valid = ~w_buf_empty | r_pend;
    assign ifu2itcm_rsp_rdata = w_buf_empty ? itcm_ram_dout : w_head[DW-1:0];

`ifdef ITCM_RSP_ERR_EN
    logic r_pend_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_err <= 1'b0;
        end else begin
            r_pend_err <= w_cmd_hs & (ifu2itcm_cmd_addr[1:0] != 2'b00);
        end
    end

    assign w_push_data      = {r_pend_err, itcm_ram_dout};
    assign ifu2itcm_rsp_err = w_buf_empty ? r_pend_err : w_head[DW];
`else
    // Byte offset is dropped: misaligned fetches read the enclosing word.
    logic w_unused_addr_lsb;
    assign w_unused_addr_lsb = ^ifu2itcm_cmd_addr[1:0];
    assign w_push_data       = itcm_ram_dout;
`endif

    itcm_rsp_buf #(
        .W (c_BUF_W)
    ) u_rsp_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_push_data),
        .o_head  (w_head),
        .o_count (w_count)
    );

endmodule : itcm_ctrl

`default_nettype wire

// File: tb/tb_itcm_ctrl.sv
// ============================================================================
//  Module  : tb_itcm_ctrl
//  Purpose : Self-checking bench for itcm_ctrl with a behavioural SRAM.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_itcm_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        ram_cs;
    logic [13:0] ram_addr;
    logic [31:0] ram_dout;
`ifdef ITCM_RSP_ERR_EN
    logic        rsp_err;
`endif

    int total;
    int bad;

    itcm_ctrl #(
        .ADDR_W (16),
        .DW     (32),
        .RAM_AW (14)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ifu2itcm_cmd_valid (cmd_valid),
        .ifu2itcm_cmd_ready (cmd_ready),
        .ifu2itcm_cmd_addr  (cmd_addr),
        .ifu2itcm_rsp_valid (rsp_valid),
        .ifu2itcm_rsp_ready (rsp_ready),
        .ifu2itcm_rsp_rdata (rsp_rdata),
`ifdef ITCM_RSP_ERR_EN
        .ifu2itcm_rsp_err   (rsp_err),
`endif
        .itcm_ram_cs        (ram_cs),
        .itcm_ram_addr      (ram_addr),
        .itcm_ram_dout      (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected content of SRAM word k.
    function automatic logic [31:0] mw(input int k);
        return (k == 4) ? 32'h0000_0013 : (32'hC0DE_0000 | 32'(k));
    endfunction

    // Single-port SRAM, 1-cycle read latency.
    logic [31:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = mw(i);
        ram_dout = '0;
    end
    always @(posedge clk) begin
        if (ram_cs) ram_dout <= mem[ram_addr[7:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        v;
        logic [15:0] a;
        logic        rr;
        logic        e_rdy;
        logic        e_cs;
        logic [13:0] e_ra;
        logic        e_rv;
        logic [31:0] e_rd;
        logic        e_err;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic v, input logic [15:0] a, input logic rr,
                       input logic e_rdy, input logic e_cs, input logic [13:0] e_ra,
                       input logic e_rv, input logic [31:0] e_rd, input logic e_err);
        vec_t t;
        t.v = v; t.a = a; t.rr = rr; t.e_rdy = e_rdy; t.e_cs = e_cs; t.e_ra = e_ra;
        t.e_rv = e_rv; t.e_rd = e_rd; t.e_err = e_err;
        tv.push_back(t);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        rsp_ready = 1'b0;

        // ---------------- vector table (one entry per clock) ---------------
        //   v  addr     rr  rdy cs ram_a  rv rdata      err
        // single fetch
        add(1, 16'h0010, 1,  1, 1, 14'h4,  0, 32'h0,     0);
        add(0, 16'h0000, 1,  1, 0, 14'h0,  1, mw(4),     0);
        add(0, 16'h0000, 1,  1, 0, 14'h0,  0, 32'h0,     0);
        // streaming 8 fetches, responses on consecutive cycles
        for (int k = 0; k < 8; k++) begin
            add(1, 16'(k*4), 1, 1, 1, 14'(k), (k != 0), (k != 0) ? mw(k-1) : 32'h0, 0);
        end
        add(0, 16'h0000, 1,  1, 0, 14'h0,  1, mw(7),     0);
        add(0, 16'h0000, 1,  1, 0, 14'h0,  0, 32'h0,     0);
        // backpressure: two accepted, then cmd_ready low until pops
        add(1, 16'h0040, 0,  1, 1, 14'h10, 0, 32'h0,     0);
        add(1, 16'h0044, 0,  1, 1, 14'h11, 1, mw(16),    0);
        add(1, 16'h0048, 0,  0, 0, 14'h0,  1, mw(16),    0);
        add(1, 16'h0048, 0,  0, 0, 14'h0,  1, mw(16),    0);
        add(0, 16'h0000, 1,  0, 0, 14'h0,  1, mw(16),    0);
        add(0, 16'h0000, 1,  1, 0, 14'h0,  1, mw(17),    0);
        add(0, 16'h0000, 1,  1, 0, 14'h0,  0, 32'h0,     0);
        // pop and push in the same cycle (count=1, pend=1, rsp_ready=1)
        add(1, 16'h0080, 0,  1, 1, 14'h20, 0, 32'h0,     0);
        add(1, 16'h0084, 0,  1, 1, 14'h21, 1, mw(32),    0);
        add(0, 16'h0000, 1,  0, 0, 14'h0,  1, mw(32),    0);
        add(0, 16'h0000, 1,  1, 0, 14'h0,  1, mw(33),    0);
        add(0, 16'h0000, 1,  1, 0, 14'h0,  0, 32'h0,     0);
        // misaligned fetch, then aligned fetch
        add(1, 16'h0006, 1,  1, 1, 14'h1,  0, 32'h0,     0);
        add(0, 16'h0000, 1,  1, 0, 14'h0,  1, mw(1),     1);
        add(1, 16'h0008, 1,  1, 1, 14'h2,  0, 32'h0,     0);
        add(0, 16'h0000, 1,  1, 0, 14'h0,  1, mw(2),     0);
        add(0, 16'h0000, 1,  1, 0, 14'h0,  0, 32'h0,     0);

        // ---------------- reset state ----------------
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_ram_cs",    32'(ram_cs),    32'd0);
        #21 rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- table-driven section ----------------
        for (int i = 0; i < tv.size(); i++) begin
            cmd_valid = tv[i].v;
            cmd_addr  = tv[i].a;
            rsp_ready = tv[i].rr;
            @(negedge clk);
            chk($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 32'(tv[i].e_rdy));
            chk($sformatf("v%0d_ram_cs", i),    32'(ram_cs),    32'(tv[i].e_cs));
            if (tv[i].e_cs)
                chk($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(tv[i].e_ra));
            chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(tv[i].e_rv));
            if (tv[i].e_rv) begin
                chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, tv[i].e_rd);
`ifdef ITCM_RSP_ERR_EN
                chk($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'(tv[i].e_err));
`endif
            end
`ifdef ITCM_RSP_ERR_EN
            else begin
                chk($sformatf("v%0d_rsp_err_idle", i), 32'(rsp_err), 32'd0);
            end
`endif
            @(posedge clk); #1;
        end

        // ---------------- reset mid-operation ----------------
        cmd_valid = 1'b1; cmd_addr = 16'h0100; rsp_ready = 1'b0;
        @(posedge clk); #1;
        cmd_addr = 16'h0104;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_full_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("mid_full_rdata",     rsp_rdata,      mw(64));
        chk("mid_full_cmd_ready", 32'(cmd_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #3 rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_rsp_valid", c), 32'(rsp_valid), 32'd0);
            chk($sformatf("post_rst%0d_cmd_ready", c), 32'(cmd_ready), 32'd1);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = 16'h000C;
        @(negedge clk);
        chk("post_rst_fetch_cs", 32'(ram_cs), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_fetch_valid", 32'(rsp_valid), 32'd1);
        chk("post_rst_fetch_rdata", rsp_rdata,      mw(3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_itcm_ctrl

`default_nettype wire
